// File: rtl/demux_4bit_1to2.sv
// rtl/demux_4bit_1to2.sv - steers a tagged word stream into two independently handshaked FIFO channels
// Each channel is a first-word-fall-through FIFO; the counters track words accepted per channel.

module demux_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             head_valid,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  // Storage is not reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_valid = (count != '0);
  assign head       = head_valid ? mem[rd_ptr] : '0;
  assign full       = (count == FULL_CNT);

endmodule

module demux_4bit_1to2 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             s,
  input  logic             d_valid,
  output logic             d_ready,
  output logic [WIDTH-1:0] ya,
  output logic             ya_valid,
  input  logic             ya_ready,
  output logic [WIDTH-1:0] yb,
  output logic             yb_valid,
  input  logic             yb_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  logic full_a;
  logic full_b;
  logic push_a;
  logic push_b;
  logic pop_a;
  logic pop_b;

  // Ready looks only at the selected channel's fullness, never at a same-cycle pop.
  assign d_ready = rst_n && (s ? !full_b : !full_a);
  assign push_a  = d_valid && d_ready && !s;
  assign push_b  = d_valid && d_ready && s;
  assign pop_a   = ya_valid && ya_ready;
  assign pop_b   = yb_valid && yb_ready;

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_a),
    .push_data  (d),
    .pop        (pop_a),
    .head       (ya),
    .head_valid (ya_valid),
    .full       (full_a)
  );

  demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push_b),
    .push_data  (d),
    .pop        (pop_b),
    .head       (yb),
    .head_valid (yb_valid),
    .full       (full_b)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (push_a) begin
        cnt_a <= cnt_a + 1'b1;
      end
      if (push_b) begin
        cnt_b <= cnt_b + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_demux_4bit_1to2.sv
// tb/tb_demux_4bit_1to2.sv - directed self-checking bench for demux_4bit_1to2

module tb_demux_4bit_1to2;

  logic       clk;
  logic       rst_n;
  logic [3:0] d;
  logic       s;
  logic       d_valid;
  logic       d_ready;
  logic [3:0] ya;
  logic       ya_valid;
  logic       ya_ready;
  logic [3:0] yb;
  logic       yb_valid;
  logic       yb_ready;
  logic [7:0] cnt_a;
  logic [7:0] cnt_b;

  int tests = 0;
  int fails = 0;

  demux_4bit_1to2 #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .d        (d),
    .s        (s),
    .d_valid  (d_valid),
    .d_ready  (d_ready),
    .ya       (ya),
    .ya_valid (ya_valid),
    .ya_ready (ya_ready),
    .yb       (yb),
    .yb_valid (yb_valid),
    .yb_ready (yb_ready),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; d = 4'h0; s = 1'b0; d_valid = 1'b0; ya_ready = 1'b0; yb_ready = 1'b0;
    #2;
    check("rst_d_ready", d_ready, 0);
    check("rst_ya_valid", ya_valid, 0);
    check("rst_yb_valid", yb_valid, 0);
    step();
    step();
    rst_n = 1'b1;
    #1;
    check("idle_ya_valid", ya_valid, 0);
    check("idle_yb_valid", yb_valid, 0);
    check("idle_ya", ya, 0);
    check("idle_yb", yb, 0);
    check("idle_cnt_a", cnt_a, 0);
    check("idle_cnt_b", cnt_b, 0);
    check("idle_d_ready", d_ready, 1);

    // Routing
    ya_ready = 1'b1; yb_ready = 1'b1;
    d = 4'b1111; s = 1'b0; d_valid = 1'b1;
    step();
    d = 4'b0000; s = 1'b1;
    check("route_ya_valid", ya_valid, 1);
    check("route_ya", ya, 4'hF);
    check("route_yb_empty", yb_valid, 0);
    step();
    d_valid = 1'b0;
    check("route_yb_valid", yb_valid, 1);
    check("route_yb", yb, 4'h0);
    check("route_ya_popped", ya_valid, 0);
    check("route_cnt_a", cnt_a, 1);
    check("route_cnt_b", cnt_b, 1);
    step();
    check("route_yb_popped", yb_valid, 0);

    // Backpressure on A, B still flows
    ya_ready = 1'b0;
    d = 4'h3; s = 1'b0; d_valid = 1'b1;
    step();
    d = 4'h5;
    step();
    check("bp_ya_head", ya, 4'h3);
    check("bp_cnt_a", cnt_a, 3);
    d = 4'h7; s = 1'b0;
    #1;
    check("bp_d_ready_full", d_ready, 0);
    step();
    check("bp_no_accept", cnt_a, 3);
    check("bp_ya_stable", ya, 4'h3);
    d = 4'hA; s = 1'b1;
    #1;
    check("bp_d_ready_b", d_ready, 1);
    step();
    d_valid = 1'b0;
    check("bp_yb_valid", yb_valid, 1);
    check("bp_yb", yb, 4'hA);
    check("bp_cnt_b", cnt_b, 2);
    ya_ready = 1'b1;
    step();
    s = 1'b0;
    #1;
    check("bp_ya_second", ya, 4'h5);
    check("bp_d_ready_after_pop", d_ready, 1);
    check("bp_yb_popped", yb_valid, 0);
    step();
    check("bp_ya_drained", ya_valid, 0);

    // Full with same-cycle pop
    ya_ready = 1'b0;
    d = 4'h1; s = 1'b0; d_valid = 1'b1;
    step();
    d = 4'h2;
    step();
    ya_ready = 1'b1;
    d = 4'h9;
    #1;
    check("full_pop_d_ready", d_ready, 0);
    step();
    check("full_pop_cnt_a", cnt_a, 5);
    check("full_pop_ya", ya, 4'h2);
    check("full_pop_ready_back", d_ready, 1);
    step();
    d_valid = 1'b0;
    check("full_pp_cnt_a", cnt_a, 6);
    check("full_pp_ya", ya, 4'h9);
    check("full_pp_ya_valid", ya_valid, 1);
    step();
    check("full_pp_drained", ya_valid, 0);

    // Counter wrap on B: 254 more words take cnt_b from 2 through 255 to 0
    s = 1'b1; d_valid = 1'b1;
    for (int i = 0; i < 253; i++) begin
      d = i[3:0];
      step();
    end
    check("wrap_cnt_b_255", cnt_b, 255);
    d = 4'hC;
    step();
    d_valid = 1'b0;
    check("wrap_cnt_b_0", cnt_b, 0);
    check("wrap_cnt_a", cnt_a, 6);
    check("wrap_yb_last", yb, 4'hC);
    step();
    check("wrap_yb_drained", yb_valid, 0);

    // Mid-operation asynchronous reset
    ya_ready = 1'b0; yb_ready = 1'b0;
    d = 4'hC; s = 1'b0; d_valid = 1'b1;
    step();
    d = 4'hD;
    step();
    d = 4'hE; s = 1'b1;
    step();
    d_valid = 1'b0;
    check("mid_ya_valid", ya_valid, 1);
    check("mid_yb_valid", yb_valid, 1);
    check("mid_cnt_a", cnt_a, 8);
    check("mid_cnt_b", cnt_b, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ya_valid", ya_valid, 0);
    check("mid_rst_yb_valid", yb_valid, 0);
    check("mid_rst_ya", ya, 0);
    check("mid_rst_cnt_a", cnt_a, 0);
    check("mid_rst_cnt_b", cnt_b, 0);
    check("mid_rst_d_ready", d_ready, 0);
    #1;
    rst_n = 1'b1;
    ya_ready = 1'b1; yb_ready = 1'b1;
    step();
    check("post_rst_ya_valid", ya_valid, 0);
    check("post_rst_yb_valid", yb_valid, 0);
    d = 4'h6; s = 1'b0; d_valid = 1'b1;
    step();
    d_valid = 1'b0;
    check("post_rst_ya", ya, 4'h6);
    check("post_rst_cnt_a", cnt_a, 1);
    check("post_rst_yb_still", yb_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/demux_4bit_1to2.md
Name: demux_4bit_1to2

Overview:
- Receive-side counterpart of the 4-bit 2-to-1 mux: takes one shared 4-bit word stream tagged by a select bit and steers each word to channel A (s=0) or channel B (s=1).
- Each channel has its own small FIFO and valid/ready handshake, so one stalled consumer does not block the other unless the stalled channel's FIFO is full.
- Sits at the far end of the shared nibble link, feeding two independent consumers.

Parameters:
- WIDTH, 4, data word width in bits.
- DEPTH, 2, entries per channel FIFO; power of two, ≥2.
- CNT_W, 8, width of per-channel accepted-word counters.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- d  input  WIDTH  incoming word.
- s  input  1  channel tag for d: 0 routes to A, 1 routes to B.
- d_valid  input  1  d/s valid this cycle.
- d_ready  output  1  block can accept d this cycle.
- ya  output  WIDTH  channel A head word.
- ya_valid  output  1  ya holds a valid word.
- ya_ready  input  1  channel A consumer accepts ya.
- yb  output  WIDTH  channel B head word.
- yb_valid  output  1  yb holds a valid word.
- yb_ready  input  1  channel B consumer accepts yb.
- cnt_a  output  CNT_W  words accepted into A since reset.
- cnt_b  output  CNT_W  words accepted into B since reset.

Behaviour:
- Reset (rst_n low, asynchronous): all FIFO pointers and occupancy counts clear.
  - ya_valid=0, yb_valid=0, ya=0, yb=0, cnt_a=0, cnt_b=0.
  - d_ready=0 while rst_n is low.
  - Reset mid-transfer discards all buffered words; nothing is delivered after release.
- After reset release, d_ready is purely combinational: d_ready = (s==0) ? !full_a : !full_b.
  - It depends on s and FIFO state only, never on d_valid.
- Accept condition: d_valid && d_ready at a rising edge.
  - The word is pushed into the FIFO chosen by s.
  - The matching counter increments by 1; it wraps from 2^CNT_W-1 to 0.
  - When d_valid is low, s is ignored and nothing changes.
- Pop: a word leaves channel A on ya_valid && ya_ready at a rising edge; channel B likewise.
  - After a pop, the next entry (if any) is presented in the following cycle.
- Output timing is first-word-fall-through from registered storage.
  - A word accepted at edge N appears on ya/yb with valid=1 in the cycle after edge N (latency 1).
  - There is no combinational path from d to ya/yb.
- When a channel is empty: valid=0 and its data output is driven 0.
- A channel's data and valid stay stable while valid=1 and ready=0. Ordering within a channel is strict FIFO.
- Full FIFO:
  - d_ready is low when the selected FIFO holds DEPTH words, even if that channel pops in the same cycle. There is no ready-through-pop path.
  - A word is accepted only on a cycle where its own channel is not full.
  - A word for the other, non-full channel is accepted normally.
- Simultaneous push and pop on the same non-full channel: occupancy is unchanged and both operations take effect.
- Simultaneous pops on A and B are independent.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked in a separate log2(DEPTH)+1-bit count so that full and empty are distinguishable.
- No FSM beyond the per-channel FIFO state (empty / partial / full), derived from occupancy:
  - empty→partial on push only.
  - partial→full when a push without pop reaches DEPTH.
  - full→partial on pop.
  - partial→empty when a pop without push reaches 0.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles, then release → ya_valid=yb_valid=0, ya=yb=0, cnt_a=cnt_b=0, d_ready=1 after release.
- Routing: push d=4'b1111,s=0 then d=4'b0000,s=1 with both readies=1 → ya=4'b1111 valid one cycle after its accept; yb=4'b0000 valid one cycle after its accept; cnt_a=1, cnt_b=1.
- Backpressure: ya_ready=0; push 4'h3,4'h5 to A → d_ready=0 when s=0; push 4'hA with s=1 is still accepted and appears on yb. Raise ya_ready → ya delivers 3 then 5 in order; d_ready returns to 1 for s=0 in the cycle after the first pop.
- Full plus same-cycle pop: A full (DEPTH=2), ya_ready=1, d_valid=1, s=0 → d_ready=0 that cycle; the word is accepted the next cycle; occupancy never exceeds 2.
- Counter wrap: 256 accepted words to B → cnt_b goes 255→0, cnt_a unchanged.
- Mid-operation reset: A holds 2 words, B holds 1; pulse rst_n low asynchronously between edges → all valids drop immediately, counters 0, and no stale word appears after release.
